bubsysrom_sram_arb: RTL and testbench

BUBSYSROM_SRAM_ARB -- requirements
Module: bubsysrom_sram_arb

---
 rtl/bubsysrom_sram_arb_if.sv | 59 +++++
 rtl/bubsysrom_sram_arb.sv | 168 ++++++++++++++++
 tb/tb_bubsysrom_sram_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bubsysrom_sram_arb_if.sv
// ---------------------------------------------------------------------------
// bubsysrom_sram_arb_if
//   Bundles the two requester ports, the SRAM command/data port and the busy
//   flag of bubsysrom_sram_arb. Signal names keep the legacy port names so
//   existing connection lists translate one-to-one.
//
//   Parameters : AW  SRAM address width
//                DW  SRAM data width
//   Modports   : slave   - the arbiter (consumes requests, drives SRAM command)
//                master  - the environment (requesters + SRAM device)
//
//   Requester n (n = 0/1):
//     i_REQn, i_WEn, i_ADDRn, i_DINn   request, 1=write, address, write data
//     o_ACKn                           one-cycle grant acknowledge
//     o_DOUTn, o_RVALIDn               read data (held), new-data pulse
//   SRAM side:
//     o_SRAM_ADDR, o_SRAM_DIN, o_SRAM_RD, o_SRAM_WR   registered command
//     i_SRAM_DOUT                                     read data, 1 cycle late
//   o_BUSY                             clear sweep in progress
// ---------------------------------------------------------------------------
interface bubsysrom_sram_arb_if #(
  parameter int AW = 10,
  parameter int DW = 8
) ();
  logic          i_REQ0;
  logic          i_REQ1;
  logic          i_WE0;
  logic          i_WE1;
  logic [AW-1:0] i_ADDR0;
  logic [AW-1:0] i_ADDR1;
  logic [DW-1:0] i_DIN0;
  logic [DW-1:0] i_DIN1;
  logic          o_ACK0;
  logic          o_ACK1;
  logic [DW-1:0] o_DOUT0;
  logic [DW-1:0] o_DOUT1;
  logic          o_RVALID0;
  logic          o_RVALID1;
  logic [AW-1:0] o_SRAM_ADDR;
  logic [DW-1:0] o_SRAM_DIN;
  logic          o_SRAM_RD;
  logic          o_SRAM_WR;
  logic [DW-1:0] i_SRAM_DOUT;
  logic          o_BUSY;

  modport slave (
    input  i_REQ0, i_REQ1, i_WE0, i_WE1, i_ADDR0, i_ADDR1, i_DIN0, i_DIN1,
    input  i_SRAM_DOUT,
    output o_ACK0, o_ACK1, o_DOUT0, o_DOUT1, o_RVALID0, o_RVALID1,
    output o_SRAM_ADDR, o_SRAM_DIN, o_SRAM_RD, o_SRAM_WR, o_BUSY
  );

  modport master (
    output i_REQ0, i_REQ1, i_WE0, i_WE1, i_ADDR0, i_ADDR1, i_DIN0, i_DIN1,
    output i_SRAM_DOUT,
    input  o_ACK0, o_ACK1, o_DOUT0, o_DOUT1, o_RVALID0, o_RVALID1,
    input  o_SRAM_ADDR, o_SRAM_DIN, o_SRAM_RD, o_SRAM_WR, o_BUSY
  );
endinterface

// File: rtl/bubsysrom_sram_arb.sv
// ---------------------------------------------------------------------------
// bubsysrom_sram_arb
//   Two-requester round-robin arbiter in front of a single-port synchronous
//   SRAM. Each grant occupies two cycles (IDLE -> ISSUE -> IDLE), so grants
//   can land on edges k and k+2. A read granted at edge k is captured into
//   o_DOUTn at edge k+2 and flagged with a one-cycle o_RVALIDn pulse.
//
//   Ports:
//     i_MCLK   clock, everything on its rising edge
//     i_RST_n  synchronous active-low reset
//     bus      bubsysrom_sram_arb_if.slave (requesters, SRAM port, o_BUSY)
//
//   Build option:
//     SRAM_ARB_CLEAR_EN  when defined, every reset release is followed by a
//                        sweep writing 0 to all 2^AW locations (o_BUSY high,
//                        requests held off). Undefined: no sweep, o_BUSY = 0.
// ---------------------------------------------------------------------------
module bubsysrom_sram_arb #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic                i_MCLK,
  input  logic                i_RST_n,
  bubsysrom_sram_arb_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
`ifdef SRAM_ARB_CLEAR_EN
  localparam logic [1:0] CLEAR = 2'd2;
`endif

  logic [1:0]    state;
  logic          rr_pref;     // requester favoured on the next tie
  logic          ack0, ack1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] dout0, dout1;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic          sram_rd, sram_wr;
  // Read in flight: set at the ISSUE->IDLE edge, SRAM data is captured on
  // the following edge. cap_who is only sampled at that capture edge, so a
  // new grant at the same edge may overwrite it safely.
  logic          cap_pend;
  logic          cap_who;

  logic          gnt_any;
  logic          gnt_sel;
  logic          gnt_we;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_din;

  always_comb begin
    gnt_any = bus.i_REQ0 | bus.i_REQ1;
    if (bus.i_REQ0 && bus.i_REQ1) begin
      gnt_sel = rr_pref;
    end else begin
      gnt_sel = bus.i_REQ1;
    end
    gnt_we   = gnt_sel ? bus.i_WE1   : bus.i_WE0;
    gnt_addr = gnt_sel ? bus.i_ADDR1 : bus.i_ADDR0;
    gnt_din  = gnt_sel ? bus.i_DIN1  : bus.i_DIN0;
  end

`ifdef SRAM_ARB_CLEAR_EN
  logic clr_todo;             // sweep owed since the last reset
  logic busy;

  assign bus.o_BUSY = busy;
`else
  assign bus.o_BUSY = 1'b0;
`endif

  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      state     <= IDLE;
      rr_pref   <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      dout0     <= '0;
      dout1     <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_rd   <= 1'b0;
      sram_wr   <= 1'b0;
      cap_pend  <= 1'b0;
      cap_who   <= 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
      clr_todo  <= 1'b1;
      busy      <= 1'b0;
`endif
    end else begin
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      cap_pend <= 1'b0;

      if (cap_pend) begin
        if (cap_who) begin
          dout1   <= bus.i_SRAM_DOUT;
          rvalid1 <= 1'b1;
        end else begin
          dout0   <= bus.i_SRAM_DOUT;
          rvalid0 <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
`ifdef SRAM_ARB_CLEAR_EN
          if (clr_todo) begin
            clr_todo  <= 1'b0;
            busy      <= 1'b1;
            state     <= CLEAR;
            sram_addr <= '0;
            sram_din  <= '0;
            sram_wr   <= 1'b1;
          end else
`endif
          if (gnt_any) begin
            state     <= ISSUE;
            rr_pref   <= ~gnt_sel;
            ack0      <= ~gnt_sel;
            ack1      <= gnt_sel;
            sram_addr <= gnt_addr;
            sram_din  <= gnt_din;
            sram_wr   <= gnt_we;
            sram_rd   <= ~gnt_we;
            cap_who   <= gnt_sel;
          end
        end
        ISSUE: begin
          state    <= IDLE;
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          sram_rd  <= 1'b0;
          sram_wr  <= 1'b0;
          cap_pend <= sram_rd;
        end
`ifdef SRAM_ARB_CLEAR_EN
        CLEAR: begin
          if (sram_addr == '1) begin
            state   <= IDLE;
            sram_wr <= 1'b0;
            busy    <= 1'b0;
          end else begin
            sram_addr <= sram_addr + AW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ACK0      = ack0;
  assign bus.o_ACK1      = ack1;
  assign bus.o_DOUT0     = dout0;
  assign bus.o_DOUT1     = dout1;
  assign bus.o_RVALID0   = rvalid0;
  assign bus.o_RVALID1   = rvalid1;
  assign bus.o_SRAM_ADDR = sram_addr;
  assign bus.o_SRAM_DIN  = sram_din;
  assign bus.o_SRAM_RD   = sram_rd;
  assign bus.o_SRAM_WR   = sram_wr;

endmodule

// File: tb/tb_bubsysrom_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_bubsysrom_sram_arb
//   Bench for bubsysrom_sram_arb (AW=10, DW=8) with a behavioural SRAM.
//   A transaction-level model tracks grant slots, round-robin order, pending
//   read returns and the expected memory image; one negedge process compares
//   every DUT output against it. Directed scenarios add literal checks, then
//   a randomized phase runs both requesters. Define SRAM_ARB_CLEAR_EN for
//   both DUT and bench to exercise the clear sweep.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bubsysrom_sram_arb;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bubsysrom_sram_arb_if #(.AW(AW), .DW(DW)) bus ();

  bubsysrom_sram_arb #(.AW(AW), .DW(DW)) dut (
    .i_MCLK (clk),
    .i_RST_n(rst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // ---------------- behavioural SRAM ----------------
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SRAM_ARB_CLEAR_EN
      mem[i]     = 8'hFF;
      ref_mem[i] = 8'hFF;
`else
      mem[i]     = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
`endif
    end
  end

  always @(posedge clk) begin
    if (bus.o_SRAM_WR) mem[bus.o_SRAM_ADDR] <= bus.o_SRAM_DIN;
    if (bus.o_SRAM_RD) bus.i_SRAM_DOUT <= mem[bus.o_SRAM_ADDR];
  end

  // ---------------- reference model ----------------
  typedef struct {
    longint        due;
    int            who;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rdq[$];
  longint        cyc       = 0;
  longint        next_free = 0;   // first edge at which a grant may happen
  int            last_g    = 1;   // 1 => requester 0 wins the first tie
  int            clr_idx   = -1;  // next clear address, -1 when no sweep
  bit            started   = 0;
  int            g;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_din;
  rd_t           r;

  logic [1:0]    m_ack, m_rv;
  logic          m_rd, m_wr, m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_dout0, m_dout1;

  always @(posedge clk) begin
    cyc++;
    started = 1;
    m_ack   = '0;
    m_rv    = '0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    if (!rst_n) begin
      m_addr    = '0;
      m_din     = '0;
      m_dout0   = '0;
      m_dout1   = '0;
      m_busy    = 1'b0;
      last_g    = 1;
      next_free = 0;
      rdq.delete();
`ifdef SRAM_ARB_CLEAR_EN
      clr_idx = 0;
`else
      clr_idx = -1;
`endif
    end else begin
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        r = rdq.pop_front();
        if (r.who == 0) m_dout0 = r.data;
        else            m_dout1 = r.data;
        m_rv[r.who] = 1'b1;
      end
      if (clr_idx >= 0) begin
        if (clr_idx < DEPTH) begin
          m_wr    = 1'b1;
          m_addr  = AW'(clr_idx);
          m_din   = '0;
          m_busy  = 1'b1;
          ref_mem[clr_idx] = '0;
          clr_idx++;
        end else begin
          m_busy  = 1'b0;
          clr_idx = -1;
        end
      end else if (cyc >= next_free && (bus.i_REQ0 || bus.i_REQ1)) begin
        if (bus.i_REQ0 && bus.i_REQ1) g = 1 - last_g;
        else                          g = bus.i_REQ0 ? 0 : 1;
        last_g    = g;
        next_free = cyc + 2;
        g_we   = (g == 0) ? bus.i_WE0   : bus.i_WE1;
        g_addr = (g == 0) ? bus.i_ADDR0 : bus.i_ADDR1;
        g_din  = (g == 0) ? bus.i_DIN0  : bus.i_DIN1;
        m_ack[g] = 1'b1;
        m_addr   = g_addr;
        m_din    = g_din;
        if (g_we) begin
          m_wr = 1'b1;
          ref_mem[g_addr] = g_din;
        end else begin
          m_rd = 1'b1;
          rdq.push_back('{due: cyc + 2, who: g, data: ref_mem[g_addr]});
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int ack_cnt0 = 0;
  always @(negedge clk) begin
    if (started) begin
      chk("ack0",      bus.o_ACK0,      m_ack[0]);
      chk("ack1",      bus.o_ACK1,      m_ack[1]);
      chk("rvalid0",   bus.o_RVALID0,   m_rv[0]);
      chk("rvalid1",   bus.o_RVALID1,   m_rv[1]);
      chk("dout0",     bus.o_DOUT0,     m_dout0);
      chk("dout1",     bus.o_DOUT1,     m_dout1);
      chk("sram_rd",   bus.o_SRAM_RD,   m_rd);
      chk("sram_wr",   bus.o_SRAM_WR,   m_wr);
      chk("sram_addr", bus.o_SRAM_ADDR, m_addr);
      chk("sram_din",  bus.o_SRAM_DIN,  m_din);
      chk("busy",      bus.o_BUSY,      m_busy);
      chk("rd_wr_excl", bus.o_SRAM_RD & bus.o_SRAM_WR, 1'b0);
      if (bus.o_ACK0) ack_cnt0++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int n, input bit rq, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin
      bus.i_REQ0 = rq; bus.i_WE0 = we; bus.i_ADDR0 = a; bus.i_DIN0 = d;
    end else begin
      bus.i_REQ1 = rq; bus.i_WE1 = we; bus.i_ADDR1 = a; bus.i_DIN1 = d;
    end
  endtask

  function automatic logic ack_of(input int n);
    return (n == 0) ? bus.o_ACK0 : bus.o_ACK1;
  endfunction

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t, got no event expected one", name, $time);
  endtask

  task automatic wait_ack(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_of(n)) begin
        ok = 1;
        return;
      end
    end
    timeout_fail(n == 0 ? "wait_ack0" : "wait_ack1");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < DEPTH + 100; i++) begin
      @(negedge clk);
      if (!bus.o_BUSY) return;
    end
    timeout_fail("wait_idle");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle();
  endtask

  task automatic do_access(input int n, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    bit ok;
    set_req(n, 1'b1, we, a, d);
    wait_ack(n, ok);
    set_req(n, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_req(input int n);
    int unsigned lo;
    logic [AW-1:0] a;
    lo = $urandom_range(0, 15);
    a  = ($urandom_range(0, 1) == 1) ? AW'(lo) : AW'(DEPTH - 16 + int'(lo));
    set_req(n, 1'b1, 1'($urandom_range(0, 1)), a, DW'($urandom));
  endtask

  // ---------------- main sequence ----------------
  int  cnt_a, cnt_b, nseq, lat, a0lat, rvlat;
  logic [7:0] seqbits;
  bit  ok;

  initial begin
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_rst_ack0", bus.o_ACK0, 1'b0);
    chk("lit_rst_wr",   bus.o_SRAM_WR, 1'b0);
    chk("lit_rst_dout0", bus.o_DOUT0, 8'h00);
    chk("lit_rst_addr", bus.o_SRAM_ADDR, 10'h000);

`ifdef SRAM_ARB_CLEAR_EN
    // request raised exactly at release must wait out the whole sweep
    set_req(0, 1'b1, 1'b0, 10'h005, 8'h00);
    rst_n = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < DEPTH + 100; i++) begin
      @(negedge clk);
      if (bus.o_ACK0) cnt_b++;
      if (bus.o_BUSY) cnt_a++;
      else if (i > 0) break;
    end
    chk("lit_clear_busy_cycles", cnt_a, 1024);
    chk("lit_clear_no_early_ack", cnt_b, 0);
    wait_ack(0, ok);
    set_req(0, 1'b0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
    cnt_a = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != 8'h00) cnt_a++;
    chk("lit_clear_all_zero", cnt_a, 0);
`else
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // round robin with both requests held: grants 0,1,0,1
    do_reset();
    set_req(0, 1'b1, 1'b0, 10'h100, 8'h00);
    set_req(1, 1'b1, 1'b0, 10'h200, 8'h00);
    nseq    = 0;
    seqbits = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_ACK1 && nseq < 8) seqbits[nseq] = 1'b1;
      if (bus.o_ACK0 || bus.o_ACK1) nseq++;
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    chk("lit_rr_grants", nseq, 4);
    chk("lit_rr_order", seqbits, 8'b0000_1010);
    repeat (4) @(negedge clk);

    // write 0x3FF <- 0xA5, read it back
    cnt_a = ack_cnt0;
    do_access(0, 1'b1, 10'h3FF, 8'hA5);
    repeat (3) @(negedge clk);
    chk("lit_wr_ack_once", ack_cnt0 - cnt_a, 1);
    cnt_a = ack_cnt0;
    do_access(0, 1'b0, 10'h3FF, 8'h00);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (bus.o_RVALID0) break;
    end
    chk("lit_rd_latency", lat, 2);
    chk("lit_rd_data", bus.o_DOUT0, 8'hA5);
    repeat (2) @(negedge clk);
    chk("lit_rd_ack_once", ack_cnt0 - cnt_a, 1);

    // read by req1 at k, write by req0 to the same address at k+2
    do_access(0, 1'b1, 10'h010, 8'h5C);
    repeat (2) @(negedge clk);
    set_req(1, 1'b1, 1'b0, 10'h010, 8'h00);
    wait_ack(1, ok);
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(0, 1'b1, 1'b1, 10'h010, 8'h33);
    a0lat = 0;
    rvlat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_ACK0 && a0lat == 0) begin
        a0lat = i + 1;
        set_req(0, 1'b0, 1'b0, '0, '0);
      end
      if (bus.o_RVALID1 && rvlat == 0) rvlat = i + 1;
      if (a0lat != 0 && rvlat != 0) break;
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    chk("lit_overlap_rvalid_lat", rvlat, 2);
    chk("lit_overlap_ack0_lat", a0lat, 2);
    chk("lit_overlap_old_data", bus.o_DOUT1, 8'h5C);
    repeat (2) @(negedge clk);
    chk("lit_overlap_write_landed", mem[10'h010], 8'h33);

    // reset while a read is in ISSUE
    set_req(0, 1'b1, 1'b0, 10'h3FF, 8'h00);
    wait_ack(0, ok);
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("lit_abort_rd", bus.o_SRAM_RD, 1'b0);
    chk("lit_abort_ack0", bus.o_ACK0, 1'b0);
    chk("lit_abort_dout0", bus.o_DOUT0, 8'h00);
    rst_n = 1'b1;
    cnt_a = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_RVALID0 || bus.o_RVALID1) cnt_a++;
    end
    chk("lit_abort_no_rvalid", cnt_a, 0);
    wait_idle();

    // randomized traffic following the requester protocol
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        do_reset();
      end
      for (int n = 0; n < 2; n++) begin
        if ((n == 0) ? bus.i_REQ0 : bus.i_REQ1) begin
          if (ack_of(n)) begin
            if ($urandom_range(0, 9) < 7) rand_req(n);
            else set_req(n, 1'b0, 1'b0, '0, '0);
          end else if ($urandom_range(0, 99) < 4) begin
            set_req(n, 1'b0, 1'b0, '0, '0);
          end
        end else if ($urandom_range(0, 9) < 4) begin
          rand_req(n);
        end
      end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
